// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the integer register file write port.
//   REG_ADDR_W    : width of a register index (x0..x31)
//   NUM_ARCH_REGS : architectural register count including x0
//   XLEN          : widest supported register data width (WIDTH <= XLEN)
//   state_t       : write-port controller states (CLEAR, RUN)
//   wp_t          : registered write-port record (we, addr, data)
package regfile_pkg;

    localparam int unsigned REG_ADDR_W    = 5;
    localparam int unsigned NUM_ARCH_REGS = 32;
    localparam int unsigned XLEN          = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } state_t;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wp_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin grant.
//   req       in  N           request vector
//   ptr       in  $clog2(N)   highest-priority index (must be < N)
//   grant     out N           one-hot grant, zero when no request
//   grant_idx out $clog2(N)   encoded grant index, zero when no request
module rr_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned IW = $clog2(N);

    int unsigned idx;

    // Scan offsets from farthest to nearest so the request closest to ptr
    // (in wrap-around order) is the last one written and therefore wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        idx       = 0;
        for (int unsigned k = N; k > 0; k--) begin
            idx = (32'(ptr) + k - 1) % N;
            if (req[idx]) begin
                grant      = '0;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: write-port controller for the integer register file.
// After reset it clears x1..x31 through the write port (CLEAR), then
// arbitrates the port round-robin among NUM_REQ writeback requesters (RUN).
//   clk, rst                         clock, async active-high reset
//   req_valid/req_ready              per-requester handshake
//   req_rd, req_data                 packed per-requester rd / write data
//   rf_we, rf_rd_addr, rf_write_data registered write port to the file
//   init_done                        clear finished, arbitration active
//   rs1/rs2_addr, rf_rs1/rs2_data    decode-stage reads from the file
//   fwd_rs1/rs2_data                 read data, optionally forwarded
// Optional feature macro: REGFILE_WB_FORWARD_EN (forward the pending write).
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned NUM_REQ = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*5-1:0]    req_rd,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic                    rf_we,
    output logic [4:0]              rf_rd_addr,
    output logic [WIDTH-1:0]        rf_write_data,
    output logic                    init_done,
    input  logic [4:0]              rs1_addr,
    input  logic [4:0]              rs2_addr,
    input  logic [WIDTH-1:0]        rf_rs1_data,
    input  logic [WIDTH-1:0]        rf_rs2_data,
    output logic [WIDTH-1:0]        fwd_rs1_data,
    output logic [WIDTH-1:0]        fwd_rs2_data
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(NUM_ARCH_REGS - 1);

    state_t                state_q, state_d;
    logic [REG_ADDR_W-1:0] cnt_q, cnt_d;
    logic [PTR_W-1:0]      ptr_q, ptr_d;
    wp_t                   wp_q, wp_d;

    logic [NUM_REQ-1:0]    grant;
    logic [PTR_W-1:0]      grant_idx;
    logic                  handshake;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [WIDTH-1:0]      sel_data;

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req_valid),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = (state_q == RUN) ? grant : '0;
    assign handshake = |(req_valid & req_ready);
    assign init_done = (state_q == RUN);

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_rd   = req_rd[i*5 +: 5];
                sel_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        wp_d    = wp_q;
        wp_d.we = 1'b0;
        if (state_q == CLEAR) begin
            wp_d.we   = 1'b1;
            wp_d.addr = cnt_q;
            wp_d.data = '0;
            if (cnt_q == LAST_REG) begin
                state_d = RUN;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (handshake) begin
            // x0 writes are accepted and rotate priority but never reach the file
            wp_d.we   = (sel_rd != '0);
            wp_d.addr = sel_rd;
            wp_d.data = XLEN'(sel_data);
            ptr_d     = (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= REG_ADDR_W'(1);
            ptr_q   <= '0;
            wp_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            wp_q    <= wp_d;
        end
    end

    assign rf_we         = wp_q.we;
    assign rf_rd_addr    = wp_q.addr;
    assign rf_write_data = wp_q.data[WIDTH-1:0];

`ifdef REGFILE_WB_FORWARD_EN
    // Bypass the write registered last cycle that the file has not absorbed yet
    assign fwd_rs1_data = (wp_q.we && wp_q.addr == rs1_addr && rs1_addr != '0)
                          ? rf_write_data : rf_rs1_data;
    assign fwd_rs2_data = (wp_q.we && wp_q.addr == rs2_addr && rs2_addr != '0)
                          ? rf_write_data : rf_rs2_data;
`else
    logic unused_rs_addr;
    assign unused_rs_addr = ^{rs1_addr, rs2_addr};
    assign fwd_rs1_data   = rf_rs1_data;
    assign fwd_rs2_data   = rf_rs2_data;
`endif

endmodule
